// File: rtl/avion_prog_loader.sv
// Program loader and RAM-port arbiter for avion_cpu: streams words into blram from address 0
// while holding the CPU in reset, then hands the RAM port to the CPU.
module avion_prog_loader #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH:0]   i_len,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_ready,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic [DATA_WIDTH-1:0]    cpu_mdr_in,
  input  logic                     cpu_ram_wr,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_data,
  output logic                     o_ram_we,
  output logic                     o_cpu_rst,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  localparam logic [ADDRESS_WIDTH:0] DepthLen = (ADDRESS_WIDTH + 1)'(DEPTH);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]    checksum_q, checksum_d;
  logic                     done_q, done_d;

  logic [ADDRESS_WIDTH:0] len_clamped;
  logic                   start_accept;
  logic                   beat;
  logic                   last_beat;

  assign len_clamped  = (i_len > DepthLen) ? DepthLen : i_len;
  assign start_accept = i_start & ((state_q == StIdle) | (state_q == StRun));
  assign beat         = (state_q == StLoad) & i_valid;
  assign last_beat    = beat & (remaining_q == (ADDRESS_WIDTH + 1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (i_start) state_d = (len_clamped == '0) ? StFlush : StLoad;
      end
      StLoad:  if (last_beat) state_d = StFlush;
      StFlush: state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    if (start_accept) begin
      wr_ptr_d    = '0;
      remaining_d = len_clamped;
      checksum_d  = '0;
    end else if (beat) begin
      // After the DEPTH-th beat the pointer wraps, but the session has already ended.
      wr_ptr_d    = wr_ptr_q + ADDRESS_WIDTH'(1);
      remaining_d = remaining_q - (ADDRESS_WIDTH + 1)'(1);
      checksum_d  = checksum_q + i_data;
    end
    done_d = (state_q == StFlush);
  end

  always_comb begin
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_cpu_rst  = 1'b1;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    unique case (state_q)
      StLoad: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (beat) begin
          o_ram_we   = 1'b1;
          o_ram_addr = wr_ptr_q;
          o_ram_data = i_data;
        end
      end
      StFlush: o_busy = 1'b1;
      StRun: begin
        o_cpu_rst  = 1'b0;
        o_ram_we   = cpu_ram_wr;
        o_ram_addr = cpu_mar;
        o_ram_data = cpu_mdr_in;
      end
      default: ;
    endcase
  end

  assign o_done     = done_q;
  assign o_checksum = checksum_q;

endmodule
